// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel programmable clock divider.
package clk_div_pkg;

  localparam int MIN_DIV         = 2;
  localparam int DEFAULT_DIV_16K = 130;

  function automatic logic div_valid(input logic [31:0] n);
    return n >= 32'(MIN_DIV);
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: period counter, active/pending divisor and registered outputs.
module clock_divider_channel
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = DEFAULT_DIV_16K
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] val_i,
  output logic             slow_clk_o,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             slow_clk_q, slow_clk_d;
  logic             tick_q, tick_d;
  logic             apply;

  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    apply    = 1'b0;

    if (!enable_i) begin
      cnt_d = '0;
      apply = pend_v_q;
    end else if (cnt_q == div_q - 1'b1) begin
      cnt_d = '0;
      apply = pend_v_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // A divisor only changes where the counter restarts, so no runt period is possible.
    if (apply) begin
      div_d    = pend_q;
      pend_v_d = 1'b0;
    end

    // A write landing on the apply cycle is held for the following boundary.
    if (wr_i) begin
      pend_d   = val_i;
      pend_v_d = 1'b1;
    end

    // Outputs are registered against the next counter value so they track cnt cycle for cycle.
    slow_clk_d = enable_i && (cnt_d >= (div_d >> 1));
    tick_d     = enable_i && (cnt_d == div_d - 1'b1);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      div_q      <= WIDTH'(DEFAULT_DIV);
      pend_q     <= WIDTH'(DEFAULT_DIV);
      pend_v_q   <= 1'b0;
      slow_clk_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      slow_clk_q <= slow_clk_d;
      tick_q     <= tick_d;
    end
  end

  assign slow_clk_o = slow_clk_q;
  assign tick_o     = tick_q;

endmodule

// File: rtl/clock_divider.sv
// Multi-channel programmable clock divider: write decode, ack/err strobes and channel array.
module clock_divider
  import clk_div_pkg::*;
#(
  parameter int  WIDTH       = 16,
  parameter int  NUM_CH      = 2,
  parameter int  DEFAULT_DIV = DEFAULT_DIV_16K,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              reset,
  input  logic              clk_in,
  input  logic [NUM_CH-1:0] enable,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [WIDTH-1:0]  div_val,
  output logic              div_ack,
  output logic              div_err,
  output logic [NUM_CH-1:0] slow_clk,
  output logic [NUM_CH-1:0] tick
);

  logic wr_ok;
  logic ack_q, err_q;

  assign wr_ok = div_wr && div_valid(32'(div_val)) && (int'(div_ch) < NUM_CH);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= wr_ok;
      err_q <= div_wr && !wr_ok;
    end
  end

  assign div_ack = ack_q;
  assign div_err = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_divider_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in     (clk_in),
      .reset      (reset),
      .enable_i   (enable[g]),
      .wr_i       (wr_ok && (div_ch == CH_W'(g))),
      .val_i      (div_val),
      .slow_clk_o (slow_clk[g]),
      .tick_o     (tick[g])
    );
  end

endmodule

// File: doc/clock_divider.md
# clock_divider

Parametrised, multi-channel programmable clock divider for the IR decoder and future peripherals. Derives NUM_CH independent slow clocks from the 2.08 MHz clk_in. Each channel has:
- a run-time-writable divisor;
- a registered, glitch-free square-wave output;
- a one-cycle tick strobe.

Divisor changes take effect only at a period boundary, so downstream state machines never see a runt pulse.

## Interface
- WIDTH, 16: counter and divisor width in bits.
- NUM_CH, 2: number of independent divider channels (1..8).
- DEFAULT_DIV, 130: divisor loaded into every channel at reset (2.08 MHz / 130 = 16 kHz).

Ports:
- reset  in  1: asynchronous, active-high reset.
- clk_in  in  1: input clock.
- enable  in  NUM_CH: per-channel run enable.
- div_wr  in  1: one-cycle divisor write strobe.
- div_ch  in  $clog2(NUM_CH) (min 1): target channel of the write.
- div_val  in  WIDTH: new divisor N.
- div_ack  out  1: one-cycle pulse, write accepted.
- div_err  out  1: one-cycle pulse, write rejected.
- slow_clk  out  NUM_CH: divided clock per channel.
- tick  out  NUM_CH: one-cycle strobe per period.

## Operation
- Per-channel registers:
  - cnt: WIDTH bits, counts 0..N-1.
  - div: active divisor N.
  - pend: pending divisor.
  - pend_v: pending-valid flag.
- Running (enable=1):
  - cnt increments each cycle.
  - At cnt==N-1, cnt wraps to 0.
  - slow_clk is a flop whose value in any cycle equals (cnt >= N>>1) for that cycle's cnt: low for N>>1 cycles, then high for N-(N>>1) cycles. Exact 50% duty for even N; odd N is high one extra cycle.
  - tick is a flop equal to (cnt==N-1) for that cycle's cnt: exactly one cycle per period.
- Disabled (enable=0):
  - cnt is forced to 0.
  - slow_clk=0, tick=0.
  - div and pend are retained.
- Divisor write (div_wr=1):
  - Valid when div_val>=2 and div_ch<NUM_CH. The value goes to pend[div_ch] and pend_v is set. div_ack=1 on the next cycle.
  - Otherwise nothing is stored and div_err=1 on the next cycle.
- Pending apply:
  - On the wrap cycle, when pend_v is set: div<=pend, pend_v<=0. The new period starts at cnt=0 with the new N.
  - A disabled channel applies pend on the next cycle.
- Write in the same cycle as a wrap: the write is stored, but that wrap uses the prior pend state. The new value applies at the following wrap.
- A second write before apply overwrites pend (last write wins). Both writes are acked.
- Channels are fully independent. A write to one channel never perturbs another.

## Timing
- Reset values, all channels:
  - cnt=0, div=DEFAULT_DIV, pend_v=0.
  - slow_clk=0, tick=0.
  - div_ack=0, div_err=0.
- Reset asserted mid-period returns to these values immediately (asynchronous). There is no partial pulse on tick.
- First tick after reset release or enable rise: N cycles after the first counting edge, i.e. in the cycle where cnt==N-1.
- First rising edge of slow_clk: N>>1 cycles after counting starts.
- div_ack/div_err latency: exactly 1 cycle after div_wr, single-cycle pulse.
- Back-to-back writes on consecutive cycles are all accepted, with no stall.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package clk_div_pkg holds:
  - constants MIN_DIV=2 and DEFAULT_DIV_16K=130;
  - a function div_valid(N) returning N>=MIN_DIV.
- Sub-module clock_divider_channel holds cnt/div/pend/pend_v, slow_clk and tick for one channel.
- The top level generates NUM_CH instances and decodes div_wr/div_ch into per-channel write strobes.
- The top level also generates div_ack/div_err.

## Test plan
- Reset, enable=all 1s, no writes: slow_clk[0] period 130 cycles, low 65 then high 65. tick[0] pulses every 130 cycles, first in cycle 130 after release.
- Write div_val=4 to ch0 mid-period: div_ack pulses 1 cycle later. The current 130-cycle period completes unchanged, then slow_clk[0] runs 2 low / 2 high. ch1 stays at 130.
- Write div_val=5 to ch1 exactly on its wrap cycle: that period still restarts with 130. The next period onward runs 2 low / 3 high with tick every 5.
- Write div_val=1, and separately div_ch=NUM_CH when NUM_CH=3: div_err pulses, div_ack stays 0, the divisor is unchanged.
- Drop enable[0] mid-period for 10 cycles, then raise it: slow_clk/tick are 0 while disabled. The first tick comes N cycles after re-enable.
- Assert reset asynchronously with slow_clk=1 and pend_v=1: all outputs go to 0 at once. After release, div=130 and the pending value is discarded.
